// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: two-flop synchroniser plus a per-channel stability counter.
// Define DEBOUNCER_EDGE_EN to build the registered o_rise/o_fall strobes; otherwise they are tied low.
module multi_debouncer #(
  parameter int unsigned      WIDTH  = 1,
  parameter int unsigned      PERIOD = 1,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_input,
  output logic [WIDTH-1:0] o_output,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_busy
);

  localparam int unsigned CW = ($clog2(PERIOD + 1) > 1) ? $clog2(PERIOD + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    ACCEPT
  } act_t;

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt [WIDTH];
  act_t             act [WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= INIT;
      sync <= INIT;
    end else begin
      meta <= i_input;
      sync <= meta;
    end
  end

  // Any sample matching the current output drops the channel back to IDLE.
  always_comb begin
    act = '{default: IDLE};
    for (int unsigned n = 0; n < WIDTH; n++) begin
      if (sync[n] == o_output[n])
        act[n] = IDLE;
      else if (cnt[n] == LAST)
        act[n] = ACCEPT;
      else
        act[n] = COUNTING;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_output <= INIT;
      for (int unsigned n = 0; n < WIDTH; n++)
        cnt[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < WIDTH; n++) begin
        case (act[n])
          ACCEPT: begin
            o_output[n] <= sync[n];
            cnt[n]      <= '0;
          end
          COUNTING: cnt[n] <= cnt[n] + CW'(1);
          default:  cnt[n] <= '0;
        endcase
      end
    end
  end

`ifdef DEBOUNCER_EDGE_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rise <= '0;
      o_fall <= '0;
    end else begin
      for (int unsigned n = 0; n < WIDTH; n++) begin
        o_rise[n] <= (act[n] == ACCEPT) &&  sync[n];
        o_fall[n] <= (act[n] == ACCEPT) && !sync[n];
      end
    end
  end
`else
  assign o_rise = '0;
  assign o_fall = '0;
`endif

  assign o_busy = |(sync ^ o_output);

endmodule
